// File: rtl/corr_branch_predictor_if.sv
`default_nettype none
// ============================================================================
//  Module      : corr_branch_predictor_if
//  Description : Port bundle for the correlating branch predictor. It carries
//                the fetch lookup, the ROB lookup and the commit update.
//    slave  (predictor) : drives init_done, the predictions and pc_hist;
//                         receives the lookup addresses and the update strobe.
//    master (driver)    : the mirror image of slave.
//  Parameters  : HIST_BITS (history width), CTR_BITS (counter width)
//  Revision    : 1.0 - initial release
// ============================================================================
interface corr_branch_predictor_if #(
   parameter int HIST_BITS = 2,
   parameter int CTR_BITS  = 2
);
   logic                 init_done;
   logic [31:0]          pc_rd_addr;
   logic                 pc_pred_taken;
   logic [CTR_BITS-1:0]  pc_pred_ctr;
   logic [HIST_BITS-1:0] pc_hist;
   logic [31:0]          rob_rd_addr;
   logic                 rob_pred_taken;
   logic                 upd_en;
   logic [31:0]          upd_addr;
   logic [HIST_BITS-1:0] upd_hist;
   logic                 upd_taken;

   modport slave (
      output init_done, pc_pred_taken, pc_pred_ctr, pc_hist, rob_pred_taken,
      input  pc_rd_addr, rob_rd_addr, upd_en, upd_addr, upd_hist, upd_taken
   );

   modport master (
      input  init_done, pc_pred_taken, pc_pred_ctr, pc_hist, rob_pred_taken,
      output pc_rd_addr, rob_rd_addr, upd_en, upd_addr, upd_hist, upd_taken
   );
endinterface
`default_nettype wire

// File: rtl/corr_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : corr_branch_predictor
//  Description : Correlating branch predictor. It holds a table of saturating
//                counters indexed by branch address and global history. It
//                has two combinational lookup ports (fetch and ROB) and one
//                commit update port. After reset the table is cleared by a
//                walk of one entry per cycle.
//  Ports       : clk             - system clock, rising edge
//                rst             - synchronous active-high reset
//                bp (slave)      - init_done, pc_*/rob_* lookups, upd_* commit
//  Macro       : GSHARE_XOR_EN - when defined, the index is the address XORed
//                with the history (DEPTH = 2^IDX_BITS). When undefined, the
//                index is {history, address} (DEPTH = 2^(IDX_BITS+HIST_BITS)).
//  Revision    : 1.0 - initial release
// ============================================================================
module corr_branch_predictor #(
   parameter int IDX_BITS  = 10,
   parameter int HIST_BITS = 2,
   parameter int CTR_BITS  = 2
) (
   input  wire logic                clk,
   input  wire logic                rst,
   corr_branch_predictor_if.slave   bp
);

`ifdef GSHARE_XOR_EN
   localparam int AW = IDX_BITS;
`else
   localparam int AW = IDX_BITS + HIST_BITS;
`endif
   localparam int                  DEPTH      = 1 << AW;
   localparam logic [AW-1:0]       C_LAST_IDX = AW'(DEPTH - 1);
   localparam logic [CTR_BITS-1:0] C_CTR_MAX  = '1;
   localparam logic [CTR_BITS-1:0] C_CTR_MIN  = '0;

   typedef enum logic [0:0] {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [AW-1:0]        r_ptr;
   logic [HIST_BITS-1:0] r_hist;
   logic [CTR_BITS-1:0]  r_table [DEPTH];

   logic                 w_run;
   logic [AW-1:0]        w_pc_idx;
   logic [AW-1:0]        w_rob_idx;
   logic [AW-1:0]        w_upd_idx;
   logic [CTR_BITS-1:0]  w_pc_ctr;
   logic [CTR_BITS-1:0]  w_rob_ctr;
   logic [CTR_BITS-1:0]  w_upd_ctr;
   logic [CTR_BITS-1:0]  w_upd_ctr_nxt;
   logic [HIST_BITS-1:0] w_hist_shift;
   logic                 w_upd_fire;
   logic                 w_tbl_we;
   logic [AW-1:0]        w_tbl_widx;
   logic [CTR_BITS-1:0]  w_tbl_wdata;
   logic                 w_unused_addr_hi;

   assign w_run = (r_state == S_RUN);

   // Index formation: lookups use the live history, and the update uses the
   // snapshot that travelled with the branch.
`ifdef GSHARE_XOR_EN
   assign w_pc_idx  = bp.pc_rd_addr[IDX_BITS-1:0]  ^ IDX_BITS'(r_hist);
   assign w_rob_idx = bp.rob_rd_addr[IDX_BITS-1:0] ^ IDX_BITS'(r_hist);
   assign w_upd_idx = bp.upd_addr[IDX_BITS-1:0]    ^ IDX_BITS'(bp.upd_hist);
`else
   assign w_pc_idx  = {r_hist,      bp.pc_rd_addr[IDX_BITS-1:0]};
   assign w_rob_idx = {r_hist,      bp.rob_rd_addr[IDX_BITS-1:0]};
   assign w_upd_idx = {bp.upd_hist, bp.upd_addr[IDX_BITS-1:0]};
`endif

   // Address bits above the index field alias onto the same entries.
   assign w_unused_addr_hi = ^{bp.pc_rd_addr[31:IDX_BITS],
                               bp.rob_rd_addr[31:IDX_BITS],
                               bp.upd_addr[31:IDX_BITS]};

   // Lookups read the array directly, so an update in the same cycle is not
   // visible until the following cycle.
   assign w_pc_ctr  = r_table[w_pc_idx];
   assign w_rob_ctr = r_table[w_rob_idx];

   assign bp.init_done      = w_run;
   assign bp.pc_pred_ctr    = w_run ? w_pc_ctr : '0;
   assign bp.pc_pred_taken  = w_run & w_pc_ctr[CTR_BITS-1];
   assign bp.rob_pred_taken = w_run & w_rob_ctr[CTR_BITS-1];
   assign bp.pc_hist        = w_run ? r_hist : '0;

   // Saturating read-modify-write of the committing counter.
   assign w_upd_ctr     = r_table[w_upd_idx];
   assign w_upd_ctr_nxt = bp.upd_taken
                          ? ((w_upd_ctr == C_CTR_MAX) ? w_upd_ctr : w_upd_ctr + 1'b1)
                          : ((w_upd_ctr == C_CTR_MIN) ? w_upd_ctr : w_upd_ctr - 1'b1);

   generate
      if (HIST_BITS == 1) begin : g_hist_one
         assign w_hist_shift = bp.upd_taken;
      end else begin : g_hist_multi
         assign w_hist_shift = {r_hist[HIST_BITS-2:0], bp.upd_taken};
      end
   endgenerate

   assign w_upd_fire  = w_run & bp.upd_en;
   assign w_tbl_we    = ~w_run | w_upd_fire;
   assign w_tbl_widx  = w_run ? w_upd_idx : r_ptr;
   assign w_tbl_wdata = w_run ? w_upd_ctr_nxt : '0;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_INIT:  if (r_ptr == C_LAST_IDX) w_state_nxt = S_RUN;
         S_RUN:   w_state_nxt = S_RUN;
         default: w_state_nxt = S_INIT;
      endcase
   end

   // ---------------- walk pointer and history ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr  <= '0;
         r_hist <= '0;
      end else begin
         if (!w_run) begin
            r_ptr <= r_ptr + 1'b1;
         end
         if (w_upd_fire) begin
            r_hist <= w_hist_shift;
         end
      end
   end

   // ---------------- counter table ----------------
   // The table has no reset of its own. The walk clears it, and an edge with
   // rst high abandons any pending write.
   always_ff @(posedge clk) begin
      if (!rst && w_tbl_we) begin
         r_table[w_tbl_widx] <= w_tbl_wdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_corr_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_corr_branch_predictor
//  Description : Directed self-checking bench for corr_branch_predictor.
//                The expected values are computed by hand. When
//                GSHARE_XOR_EN is defined, the bench runs the XOR-index
//                sequence with IDX_BITS=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_corr_branch_predictor;
`ifdef GSHARE_XOR_EN
   localparam int IDX   = 4;
   localparam int DEPTH = 16;
`else
   localparam int IDX   = 10;
   localparam int DEPTH = 4096;
`endif

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   corr_branch_predictor_if #(.HIST_BITS(2), .CTR_BITS(2)) bp ();

   corr_branch_predictor #(.IDX_BITS(IDX), .HIST_BITS(2), .CTR_BITS(2)) u_dut (
      .clk (clk),
      .rst (rst),
      .bp  (bp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic upd(input logic [31:0] a, input logic [1:0] h, input logic t);
      bp.upd_en    = 1'b1;
      bp.upd_addr  = a;
      bp.upd_hist  = h;
      bp.upd_taken = t;
      tick();
      bp.upd_en    = 1'b0;
   endtask

   // Two not-taken commits shift the live history back to 00.
   task automatic clear_hist();
      upd(32'h200, 2'b00, 1'b0);
      upd(32'h200, 2'b00, 1'b0);
   endtask

   // Counts the edges from rst deassertion until init_done rises. It also
   // checks that the outputs stay quiet and that an update strobe pulsed
   // mid-walk has no effect.
   task automatic walk(input string tag);
      int  n;
      logic bad;
      n   = 0;
      bad = 1'b0;
      while (!bp.init_done && n < DEPTH + 1000) begin
         bp.upd_en    = (n == 10);
         bp.upd_addr  = 32'h10;
         bp.upd_hist  = 2'b00;
         bp.upd_taken = 1'b1;
         tick();
         n++;
         if (!bp.init_done &&
             (bp.pc_pred_taken || bp.rob_pred_taken ||
              bp.pc_pred_ctr != 2'b00 || bp.pc_hist != 2'b00))
            bad = 1'b1;
      end
      bp.upd_en = 1'b0;
      chk(tag, n, DEPTH);
      chk({tag, "_quiet"}, bad, 0);
      chk({tag, "_hist0"}, bp.pc_hist, 2'b00);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst            = 1'b1;
      bp.pc_rd_addr  = 32'h10;
      bp.rob_rd_addr = 32'h10;
      bp.upd_en      = 1'b0;
      bp.upd_addr    = '0;
      bp.upd_hist    = '0;
      bp.upd_taken   = 1'b0;

      tick(); tick(); tick();
      chk("rst_init_done", bp.init_done, 0);
      chk("rst_pc_taken",  bp.pc_pred_taken, 0);
      chk("rst_pc_hist",   bp.pc_hist, 0);
      rst = 1'b0;
      walk("init_len");

`ifdef GSHARE_XOR_EN
      // Entry 0x5 ^ 0x3 = 0x6 is incremented. History is then returned to 00.
      upd(32'h5, 2'b11, 1'b1);
      chk("gs_hist_after", bp.pc_hist, 2'b01);
      upd(32'hC, 2'b00, 1'b0);
      upd(32'hC, 2'b00, 1'b0);
      bp.pc_rd_addr  = 32'h6;
      bp.rob_rd_addr = 32'h6;
      #1;
      chk("gs_entry6", bp.pc_pred_ctr, 2'd1);
      chk("gs_rob6",   bp.rob_pred_taken, 0);
      bp.pc_rd_addr = 32'h5;
      #1;
      chk("gs_entry5", bp.pc_pred_ctr, 2'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("gs_rst_drop", bp.init_done, 0);
      walk("gs_reinit_len");
      bp.pc_rd_addr = 32'h6;
      #1;
      chk("gs_cleared", bp.pc_pred_ctr, 2'd0);
`else
      bp.pc_rd_addr = 32'h10;
      #1;
      chk("post_init_ctr", bp.pc_pred_ctr, 2'd0);

      // Saturation up and down at entry {00, 0x10}.
      for (int i = 0; i < 4; i++) begin
         upd(32'h10, 2'b00, 1'b1);
         clear_hist();
         bp.pc_rd_addr = 32'h10;
         #1;
         chk("sat_up_ctr",   bp.pc_pred_ctr,   (i < 3) ? i + 1 : 3);
         chk("sat_up_taken", bp.pc_pred_taken, (i == 0) ? 0 : 1);
      end
      for (int i = 0; i < 4; i++) begin
         upd(32'h10, 2'b00, 1'b0);
         clear_hist();
         bp.pc_rd_addr = 32'h10;
         #1;
         chk("sat_dn_ctr",   bp.pc_pred_ctr,   (i < 2) ? 2 - i : 0);
         chk("sat_dn_taken", bp.pc_pred_taken, (i == 0) ? 1 : 0);
      end

      // History shift.
      upd(32'h300, 2'b00, 1'b1);
      chk("hist_t",   bp.pc_hist, 2'b01);
      upd(32'h300, 2'b00, 1'b1);
      chk("hist_tt",  bp.pc_hist, 2'b11);
      upd(32'h300, 2'b00, 1'b0);
      chk("hist_ttn", bp.pc_hist, 2'b10);

      // Collision: history is held at 11 by taken commits, so the lookup
      // index {11, 0x20} stays fixed across the update.
      upd(32'h200, 2'b00, 1'b1);
      upd(32'h200, 2'b00, 1'b1);
      chk("coll_hist", bp.pc_hist, 2'b11);
      bp.pc_rd_addr  = 32'h20;
      bp.rob_rd_addr = 32'h20;
      bp.upd_en      = 1'b1;
      bp.upd_addr    = 32'h20;
      bp.upd_hist    = 2'b11;
      bp.upd_taken   = 1'b1;
      #1;
      chk("coll_same_cycle", bp.pc_pred_ctr, 2'd0);
      chk("coll_rob_same",   bp.rob_pred_taken, 0);
      tick();
      chk("coll_next_cycle", bp.pc_pred_ctr, 2'd1);
      chk("coll_hist_after", bp.pc_hist, 2'b11);
      tick();
      bp.upd_en = 1'b0;
      chk("b2b_ctr",   bp.pc_pred_ctr, 2'd2);
      chk("rob_match", bp.rob_pred_taken, 1);
      chk("pc_taken",  bp.pc_pred_taken, 1);
      bp.pc_rd_addr = 32'hFFFF_FC20;
      #1;
      chk("alias", bp.pc_pred_ctr, 2'd2);

      // Mid-run reset repeats the full clear walk.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_drop", bp.init_done, 0);
      chk("mid_rst_hist", bp.pc_hist, 2'b00);
      walk("reinit_len");
      upd(32'h200, 2'b00, 1'b1);
      upd(32'h200, 2'b00, 1'b1);
      bp.pc_rd_addr  = 32'h20;
      bp.rob_rd_addr = 32'h20;
      #1;
      chk("cleared_ctr", bp.pc_pred_ctr, 2'd0);
      chk("cleared_rob", bp.rob_pred_taken, 0);
      clear_hist();
      bp.pc_rd_addr = 32'h10;
      #1;
      chk("cleared_ctr10", bp.pc_pred_ctr, 2'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
